// File: rtl/data_compare_pkg.sv
// Shared result codes, state encoding and cascade decoding for the sequential comparator.
package data_compare_pkg;

  localparam logic [2:0] CMP_GT   = 3'b100;
  localparam logic [2:0] CMP_LT   = 3'b010;
  localparam logic [2:0] CMP_EQ   = 3'b001;
  localparam logic [2:0] CMP_NONE = 3'b000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_e;

  // Only the two exact GT/LT codes count; every other pattern means "equal".
  function automatic logic [2:0] decode_cascade(input logic [2:0] casc);
    logic [2:0] res;
    case (casc)
      CMP_GT:  res = CMP_GT;
      CMP_LT:  res = CMP_LT;
      default: res = CMP_EQ;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/data_compare_seq_if.sv
// Start/busy/done handshake and operand/result bus of the sequential comparator.
interface data_compare_seq_if #(
  parameter int unsigned WIDTH = 16
);
  logic             iStart;
  logic [WIDTH-1:0] iData_a;
  logic [WIDTH-1:0] iData_b;
  logic [2:0]       iData;
  logic             oBusy;
  logic             oDone;
  logic [2:0]       oData;

  modport master (
    output iStart, iData_a, iData_b, iData,
    input  oBusy, oDone, oData
  );

  modport slave (
    input  iStart, iData_a, iData_b, iData,
    output oBusy, oDone, oData
  );
endinterface

// File: rtl/data_compare_seq_slice_compare.sv
// Combinational unsigned magnitude compare of one SLICE-bit digit.
module slice_compare #(
  parameter int unsigned SLICE = 4
) (
  input  logic [SLICE-1:0] a_i,
  input  logic [SLICE-1:0] b_i,
  output logic             gt_o,
  output logic             lt_o,
  output logic             eq_o
);

  always_comb begin
    gt_o = (a_i > b_i);
    lt_o = (a_i < b_i);
    eq_o = (a_i == b_i);
  end

endmodule

// File: rtl/data_compare_seq.sv
// Multi-cycle cascadable magnitude comparator, one slice per clock, MSB slice first.
// Define DATA_COMPARE_SIGNED_EN for two's-complement operands.
module data_compare_seq
  import data_compare_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SLICE = 4
) (
  input logic               iClk,
  input logic               iRst,
  data_compare_seq_if.slave bus
);

  localparam int unsigned NSLICE = WIDTH / SLICE;
  localparam int unsigned IdxW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IdxW-1:0] IdxMax = IdxW'(NSLICE - 1);

  typedef logic [NSLICE-1:0][SLICE-1:0] opnd_t;

  state_e          state_q, state_d;
  opnd_t           a_q, a_d;
  opnd_t           b_q, b_d;
  logic [2:0]      casc_q, casc_d;
  logic [2:0]      res_q, res_d;
  logic [IdxW-1:0] idx_q, idx_d;

  logic [SLICE-1:0] sl_a, sl_b;
  logic             sl_gt, sl_lt, sl_eq;

  always_comb begin
    sl_a = '0;
    sl_b = '0;
    for (int unsigned i = 0; i < NSLICE; i++) begin
      if (idx_q == IdxW'(i)) begin
        sl_a = a_q[i];
        sl_b = b_q[i];
      end
    end
`ifdef DATA_COMPARE_SIGNED_EN
    // Flipping the sign bit maps two's complement onto unsigned order for the top digit.
    if (idx_q == IdxMax) begin
      sl_a[SLICE-1] = ~sl_a[SLICE-1];
      sl_b[SLICE-1] = ~sl_b[SLICE-1];
    end
`endif
  end

  slice_compare #(
    .SLICE(SLICE)
  ) u_slice_compare (
    .a_i (sl_a),
    .b_i (sl_b),
    .gt_o(sl_gt),
    .lt_o(sl_lt),
    .eq_o(sl_eq)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    casc_d  = casc_q;
    res_d   = res_q;
    idx_d   = idx_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.iStart) begin
          a_d     = bus.iData_a;
          b_d     = bus.iData_b;
          casc_d  = bus.iData;
          idx_d   = IdxMax;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        unique case ({sl_gt, sl_lt, sl_eq})
          3'b100: begin
            res_d   = CMP_GT;
            state_d = ST_DONE;
          end
          3'b010: begin
            res_d   = CMP_LT;
            state_d = ST_DONE;
          end
          default: begin
            if (idx_q == '0) begin
              res_d   = decode_cascade(casc_q);
              state_d = ST_DONE;
            end else begin
              idx_d = idx_q - 1'b1;
            end
          end
        endcase
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      casc_q  <= '0;
      res_q   <= CMP_NONE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      casc_q  <= casc_d;
      res_q   <= res_d;
      idx_q   <= idx_d;
    end
  end

  assign bus.oBusy = (state_q != ST_IDLE);
  assign bus.oDone = (state_q == ST_DONE);
  assign bus.oData = res_q;

endmodule

// File: tb/tb_data_compare_seq.sv
// Randomized scoreboard bench for data_compare_seq (16/4 main unit plus an 8/8 unit).
module tb_data_compare_seq;
  import data_compare_pkg::*;

  localparam int W  = 16;
  localparam int S  = 4;
  localparam int NS = W / S;
`ifdef DATA_COMPARE_SIGNED_EN
  localparam bit Signed = 1'b1;
`else
  localparam bit Signed = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  data_compare_seq_if #(.WIDTH(W)) dif ();
  data_compare_seq_if #(.WIDTH(8)) dif8 ();

  data_compare_seq #(.WIDTH(W), .SLICE(S)) u_dut (
    .iClk(clk),
    .iRst(rst),
    .bus (dif)
  );

  data_compare_seq #(.WIDTH(8), .SLICE(8)) u_dut8 (
    .iClk(clk),
    .iRst(rst),
    .bus (dif8)
  );

  typedef struct {
    logic [2:0] res;
    int         k;
    int         acc;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       ne;
  exp_t       ge;
  int         checks   = 0;
  int         failures = 0;
  int         cyc      = 0;
  int         free_cyc = 0;
  logic [2:0] last_res = 3'b000;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (time %0t)", name, act, exp, $time);
    end
  endtask

  // Whole-value magnitude compare; equal values fall back to the cascade input.
  function automatic logic [2:0] model_res(input logic [63:0] a, input logic [63:0] b,
                                           input logic [2:0] c, input int w);
    longint sa, sb;
    sa = longint'(a);
    sb = longint'(b);
    if (Signed && a[w-1]) sa = sa - (longint'(1) << w);
    if (Signed && b[w-1]) sb = sb - (longint'(1) << w);
    if (sa > sb) return 3'b100;
    if (sa < sb) return 3'b010;
    if (c == 3'b100) return 3'b100;
    if (c == 3'b010) return 3'b010;
    return 3'b001;
  endfunction

  // Number of digits examined: up to and including the first differing one from the top.
  function automatic int model_k(input logic [63:0] a, input logic [63:0] b,
                                 input int w, input int s);
    int         nsl;
    logic [63:0] m;
    nsl = w / s;
    m   = (64'd1 << s) - 64'd1;
    for (int i = nsl - 1; i >= 0; i--) begin
      if (((a >> (i * s)) & m) != ((b >> (i * s)) & m)) return nsl - i;
    end
    return nsl;
  endfunction

  // Reference acceptance: a start is taken on an edge only once the previous compare is over.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q.delete();
      free_cyc = 0;
      last_res = 3'b000;
    end else begin
      cyc++;
      if (dif.iStart && cyc >= free_cyc) begin
        ne.res   = model_res(64'(dif.iData_a), 64'(dif.iData_b), dif.iData, W);
        ne.k     = model_k(64'(dif.iData_a), 64'(dif.iData_b), W, S);
        ne.acc   = cyc;
        free_cyc = cyc + ne.k + 2;
        exp_q.push_back(ne);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("busy", 32'(dif.oBusy), 32'(exp_q.size() != 0));
      if (dif.oDone) begin
        if (exp_q.size() == 0) begin
          check("spurious_done", 32'(dif.oDone), 32'd0);
        end else begin
          ge = exp_q.pop_front();
          check("result", 32'(dif.oData), 32'(ge.res));
          // Edges from acceptance to the done cycle; equals k (k+1 clocks from start request).
          check("latency", 32'(cyc - ge.acc), 32'(ge.k));
          last_res = ge.res;
        end
      end else begin
        check("hold", 32'(dif.oData), 32'(last_res));
        if (exp_q.size() != 0 && (cyc - exp_q[0].acc) > NS) begin
          check("done_timeout", 32'(cyc - exp_q[0].acc), 32'(exp_q[0].k));
          void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic cmp(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] c);
    dif.iStart  = 1'b1;
    dif.iData_a = a;
    dif.iData_b = b;
    dif.iData   = c;
    @(negedge clk);
    dif.iStart = 1'b0;
    for (int i = 0; i < NS + 2; i++) begin
      dif.iData_a = W'($urandom);
      dif.iData_b = W'($urandom);
      dif.iData   = 3'($urandom);
      @(negedge clk);
    end
  endtask

  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic [2:0] c);
    int         lat;
    logic [2:0] got;
    lat          = 0;
    got          = 3'b000;
    dif8.iStart  = 1'b1;
    dif8.iData_a = a;
    dif8.iData_b = b;
    dif8.iData   = c;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      dif8.iStart  = 1'b0;
      dif8.iData_a = 8'($urandom);
      if (lat == 0 && dif8.oDone) begin
        lat = i;
        got = dif8.oData;
      end
    end
    check("w8_latency", 32'(lat), 32'd2);
    check("w8_result", 32'(got), 32'(model_res(64'(a), 64'(b), c, 8)));
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic [2:0]   rc;
    int           cut;

    dif.iStart   = 1'b0;
    dif.iData_a  = '0;
    dif.iData_b  = '0;
    dif.iData    = 3'b000;
    dif8.iStart  = 1'b0;
    dif8.iData_a = '0;
    dif8.iData_b = '0;
    dif8.iData   = 3'b000;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_odata", 32'(dif.oData), 32'd0);
    check("rst_obusy", 32'(dif.oBusy), 32'd0);
    check("rst_odone", 32'(dif.oDone), 32'd0);

    cmp(16'h9000, 16'h1FFF, 3'b000);
    cmp(16'hABCD, 16'hABCD, 3'b010);
    cmp(16'hABCD, 16'hABCD, 3'b111);
    cmp(16'hFFFF, 16'h0001, 3'b000);
    cmp(16'h00F1, 16'h00F2, 3'b100);

    // Start held high: one compare per k+2 edges, extra requests dropped.
    dif.iStart  = 1'b1;
    dif.iData_a = 16'h00F1;
    dif.iData_b = 16'h00F2;
    dif.iData   = 3'b000;
    repeat (18) @(negedge clk);
    dif.iStart = 1'b0;
    repeat (NS + 3) @(negedge clk);

    // Reset in the second RUN cycle of a full-depth compare.
    dif.iStart  = 1'b1;
    dif.iData_a = 16'h1234;
    dif.iData_b = 16'h1234;
    dif.iData   = 3'b100;
    @(negedge clk);
    dif.iStart = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_odata", 32'(dif.oData), 32'd0);
    check("midrst_obusy", 32'(dif.oBusy), 32'd0);
    check("midrst_odone", 32'(dif.oDone), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    cmp(16'h1234, 16'h1234, 3'b100);

    for (int n = 0; n < 60; n++) begin
      ra  = W'($urandom);
      rb  = ra;
      cut = int'($urandom_range(0, NS));
      for (int i = 0; i < cut; i++) rb[i*S +: S] = S'($urandom);
      case ($urandom_range(0, 2))
        0:       rc = 3'b100;
        1:       rc = 3'b010;
        default: rc = 3'($urandom);
      endcase
      cmp(ra, rb, rc);
    end

    repeat (NS + 3) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    run8(8'h05, 8'h05, 3'b100);
    run8(8'h06, 8'h05, 3'b000);
    run8(8'h04, 8'h05, 3'b100);
    run8(8'h05, 8'h05, 3'b000);
    run8(8'hFF, 8'h01, 3'b000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
